// File: rtl/flp_pkg.sv
// Shared definitions for the binary32 floating-point datapath blocks:
// field widths, bias, canonical quiet NaN, operand classes and helpers.
package flp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;
    localparam int WORD_W = 1 + EXP_W + FRAC_W;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Encoding 0 is ZERO so a cleared pipeline register packs to +0.
    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } flp_class_e;

    // Denormals are classed as zero: this datapath flushes them.
    function automatic flp_class_e classify(input logic [EXP_W-1:0]  e,
                                            input logic [FRAC_W-1:0] f);
        flp_class_e c;
        if (e == '0) begin
            c = CLS_ZERO;
        end else if (e == '1) begin
            c = (f == '0) ? CLS_INF : CLS_NAN;
        end else begin
            c = CLS_NORM;
        end
        return c;
    endfunction

    // Significand with the hidden bit restored (only meaningful for NORM).
    function automatic logic [FRAC_W:0] unpack_mant(input logic [FRAC_W-1:0] f);
        return {1'b1, f};
    endfunction

    // Class of a product given the classes of its operands, in priority order.
    function automatic flp_class_e product_class(input flp_class_e ca,
                                                 input flp_class_e cb);
        flp_class_e c;
        if (ca == CLS_NAN || cb == CLS_NAN ||
            (ca == CLS_INF && cb == CLS_ZERO) ||
            (cb == CLS_INF && ca == CLS_ZERO)) begin
            c = CLS_NAN;
        end else if (ca == CLS_INF || cb == CLS_INF) begin
            c = CLS_INF;
        end else if (ca == CLS_ZERO || cb == CLS_ZERO) begin
            c = CLS_ZERO;
        end else begin
            c = CLS_NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/flp_round_pack.sv
// Round-to-nearest-even, exponent range check and binary32 packing.
// Purely combinational so it can be dropped into any pipeline stage.
module flp_round_pack
    import flp_pkg::*;
(
    input  logic              sign_i,
    input  logic signed [9:0] exp_i,
    input  logic [22:0]       mant_i,
    input  logic              guard_i,
    input  logic              round_i,
    input  logic              sticky_i,
    input  logic [1:0]        cls_i,
    output logic [31:0]       word_o
);

    logic              inc;
    logic [24:0]       sig_r;
    logic              carry;
    logic signed [9:0] exp_fin;
    logic [22:0]       frac_fin;

    // Round the significand, propagate a carry-out into the exponent, then
    // pick the packed word or the special-case substitute.
    always_comb begin
        word_o   = '0;
        inc      = guard_i & (round_i | sticky_i | mant_i[0]);
        sig_r    = {2'b01, mant_i} + {24'd0, inc};
        carry    = sig_r[24];
        exp_fin  = exp_i + {9'd0, carry};
        frac_fin = carry ? sig_r[23:1] : sig_r[22:0];

        if (cls_i == CLS_NAN) begin
            word_o = QNAN;
        end else if (cls_i == CLS_INF) begin
            word_o = {sign_i, 8'hFF, 23'd0};
        end else if (cls_i == CLS_ZERO) begin
            word_o = {sign_i, 31'd0};
        end else if (exp_fin >= 10'sd255) begin
            word_o = {sign_i, 8'hFF, 23'd0};
        end else if (exp_fin <= 10'sd0) begin
            word_o = {sign_i, 31'd0};
        end else begin
            word_o = {sign_i, exp_fin[7:0], frac_fin};
        end
    end

endmodule

// File: rtl/flp_mul_pipe.sv
// Three-stage pipelined binary32 multiplier, RNE rounding, flush-to-zero.
// Stage 1: unpack/classify and two 24x12 partial products.
// Stage 2: partial-product add, normalisation and g/r/s extraction.
// Stage 3: rounding and packing into the output register d.
module flp_mul_pipe
    import flp_pkg::*;
#(
    parameter int EXP_W   = 8,
    parameter int FRAC_W  = 23,
    parameter int LATENCY = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [EXP_W+FRAC_W:0]     a,
    input  logic [EXP_W+FRAC_W:0]     b,
    output logic [EXP_W+FRAC_W:0]     d
);

    if (EXP_W != 8 || FRAC_W != 23 || LATENCY != 3) begin : g_bad_params
        $error("flp_mul_pipe supports only EXP_W=8, FRAC_W=23, LATENCY=3");
    end

    // ---------------- stage 1 ----------------
    logic              sign1_d, sign1_q;
    logic signed [9:0] exp1_d,  exp1_q;
    logic [35:0]       pp_lo1_d, pp_lo1_q;
    logic [35:0]       pp_hi1_d, pp_hi1_q;
    flp_class_e        cls1_d,  cls1_q;
    logic [23:0]       ma, mb;

    // Unpack operands, classify the product and form the two partial products.
    always_comb begin
        ma       = unpack_mant(a[22:0]);
        mb       = unpack_mant(b[22:0]);
        sign1_d  = a[31] ^ b[31];
        cls1_d   = product_class(classify(a[30:23], a[22:0]),
                                 classify(b[30:23], b[22:0]));
        exp1_d   = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'(BIAS);
        pp_lo1_d = {12'd0, ma} * {24'd0, mb[11:0]};
        pp_hi1_d = {12'd0, ma} * {24'd0, mb[23:12]};
    end

    // Stage 1 register bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign1_q  <= 1'b0;
            exp1_q   <= '0;
            pp_lo1_q <= '0;
            pp_hi1_q <= '0;
            cls1_q   <= CLS_ZERO;
        end else begin
            sign1_q  <= sign1_d;
            exp1_q   <= exp1_d;
            pp_lo1_q <= pp_lo1_d;
            pp_hi1_q <= pp_hi1_d;
            cls1_q   <= cls1_d;
        end
    end

    // ---------------- stage 2 ----------------
    logic              sign2_d, sign2_q;
    logic signed [9:0] exp2_d,  exp2_q;
    logic [22:0]       mant2_d, mant2_q;
    logic              g2_d, g2_q, r2_d, r2_q, s2_d, s2_q;
    flp_class_e        cls2_d,  cls2_q;
    logic [47:0]       p;

    // Add the partials; the product of two [1,2) significands lies in [1,4),
    // so normalising needs at most a one-bit right shift.
    always_comb begin
        p       = {12'd0, pp_lo1_q} + {pp_hi1_q, 12'd0};
        sign2_d = sign1_q;
        cls2_d  = cls1_q;
        if (p[47]) begin
            exp2_d  = exp1_q + 10'sd1;
            mant2_d = p[46:24];
            g2_d    = p[23];
            r2_d    = p[22];
            s2_d    = |p[21:0];
        end else begin
            exp2_d  = exp1_q;
            mant2_d = p[45:23];
            g2_d    = p[22];
            r2_d    = p[21];
            s2_d    = |p[20:0];
        end
    end

    // Stage 2 register bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign2_q <= 1'b0;
            exp2_q  <= '0;
            mant2_q <= '0;
            g2_q    <= 1'b0;
            r2_q    <= 1'b0;
            s2_q    <= 1'b0;
            cls2_q  <= CLS_ZERO;
        end else begin
            sign2_q <= sign2_d;
            exp2_q  <= exp2_d;
            mant2_q <= mant2_d;
            g2_q    <= g2_d;
            r2_q    <= r2_d;
            s2_q    <= s2_d;
            cls2_q  <= cls2_d;
        end
    end

    // ---------------- stage 3 ----------------
    logic [31:0] d_d, d_q;

    flp_round_pack u_round_pack (
        .sign_i   (sign2_q),
        .exp_i    (exp2_q),
        .mant_i   (mant2_q),
        .guard_i  (g2_q),
        .round_i  (r2_q),
        .sticky_i (s2_q),
        .cls_i    (cls2_q),
        .word_o   (d_d)
    );

    // Output register bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_q <= '0;
        end else begin
            d_q <= d_d;
        end
    end

    assign d = d_q;

endmodule

// File: tb/tb_flp_mul_pipe.sv
// Bench for flp_mul_pipe: exact-integer reference model of binary32 RNE
// multiplication with flush-to-zero, a 3-deep expected queue, one compare
// process sampling #1 after every rising edge, directed literal vectors,
// a random stream and a mid-stream reset.
module tb_flp_mul_pipe;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] d;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Results of the last three sampled pairs, oldest first.
  logic [31:0] exp_q[$] = '{32'd0, 32'd0, 32'd0};

  flp_mul_pipe dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .d   (d)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic            s;
    int              ex, ey, e, msb, sh;
    logic            zx, zy, ix, iy, nx, ny;
    longint unsigned p, q, rem, half;
    logic [31:0]     r;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    if (nx || ny || (ix && zy) || (iy && zx)) return 32'h7FC0_0000;
    if (ix || iy) return {s, 8'hFF, 23'd0};
    if (zx || zy) return {s, 31'd0};
    // value = p * 2^(ex+ey-254-46)
    p = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
    msb = 0;
    for (int i = 0; i < 64; i++) if (p[i]) msb = i;
    sh   = msb - 23;
    q    = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    e = ex + ey - 127 + (msb - 46);
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    r = {s, e[7:0], q[22:0]};
    return r;
  endfunction

  // Track sampled pairs; reset discards everything in flight.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q = '{32'd0, 32'd0, 32'd0};
    end else begin
      exp_q.push_back(ref_mul(a, b));
      void'(exp_q.pop_front());
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    check("stream_d", d, exp_q[0]);
  end

  // ---------------- drivers ----------------
  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    int          sel;
    v   = $urandom;
    sel = $urandom_range(0, 15);
    case (sel)
      0:       v[30:23] = 8'h00;
      1:       v[30:0]  = {8'hFF, 23'd0};
      2:       v[30:22] = 9'h1FF;
      3:       v[30:23] = 8'($urandom_range(1, 254));
      4:       v[30:23] = 8'($urandom_range(180, 254));
      5:       v[30:23] = 8'($urandom_range(1, 70));
      default: v[30:23] = 8'($urandom_range(70, 185));
    endcase
    return v;
  endfunction

  task automatic directed(input string name, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] req);
    check({name, "_model"}, ref_mul(x, y), req);
    @(negedge clk);
    a = x;
    b = y;
    repeat (3) @(posedge clk);
    #1;
    check(name, d, req);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0;
    a   = 32'd0;
    b   = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_d", d, 32'd0);
    rst = 1'b1;

    directed("one_times_two", 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000);
    directed("norm_p47",      32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
    directed("rne_tie_odd",   32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002);
    directed("overflow_inf",  32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000);
    directed("inf_times_0",   32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
    directed("underflow_0",   32'h0080_0000, 32'h0080_0000, 32'h0000_0000);
    directed("neg_zero",      32'h8000_0000, 32'h3F80_0000, 32'h8000_0000);
    directed("nan_in",        32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000);
    directed("neg_inf",       32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      a = rand_op();
      b = rand_op();
      if (i == 50) begin
        rst = 1'b0;
        #1;
        check("mid_reset_d", d, 32'd0);
      end else begin
        rst = 1'b1;
      end
    end

    @(negedge clk);
    a = 32'd0;
    b = 32'd0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
